// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receive path with a 2-flop input synchronizer.
// The FSM samples the middle of each bit, and the payload is handed off through a valid/ready register.
// Completed frames that arrive while the register is still unconsumed are dropped and flagged as overrun.
module uart_receiver #(
  parameter int UART_BITS_TRANSFERED = 8,
  parameter int OVERSAMPLE           = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  output logic [UART_BITS_TRANSFERED-1:0] data,
  output logic                            valid,
  input  logic                            ready,
  output logic                            frame_error,
  output logic                            overrun,
  output logic                            busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE + 1);
  localparam int IDX_W = (UART_BITS_TRANSFERED > 1) ? $clog2(UART_BITS_TRANSFERED) : 1;

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(OVERSAMPLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_BITS_TRANSFERED - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [UART_BITS_TRANSFERED-1:0] shift_q, shift_d;

  logic                            rx_meta_q, rx_s_q, rx_prev_q;
  logic [UART_BITS_TRANSFERED-1:0] data_q;
  logic                            valid_q, frame_error_q, overrun_q;

  logic rx_fall;
  logic sample_now;
  logic good_frame;
  logic bad_frame;

  // Synchronize the asynchronous line, and keep one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop take its value from before the edge, so the chain shifts by exactly one stage per clock.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // State register, together with the tick counter, the bit index and the shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the shift register is cleared on reset because it is a small flop bank. A RAM would be left unreset.
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: bit timing, and data capture at the middle of each bit.
  always_comb begin
    // NOTE: every target gets a default first. Without it, a path that skips an assignment would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
          cnt_d   = HALF_BIT;
        end
      end
      S_START: begin
        if (!sample_now) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          state_d = S_DATA;
          cnt_d   = FULL_BIT;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;  // line went high again: treat the low pulse as a glitch
        end
      end
      S_DATA: begin
        if (!sample_now) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_BIT;
          if (idx_q == LAST_IDX) state_d = S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_STOP: begin
        if (!sample_now)     cnt_d   = cnt_q - 1'b1;
        else if (rx_s_q)     state_d = S_IDLE;
        else                 state_d = S_BREAK;
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: busy, plus the frame-outcome strobes taken at the stop-bit sample.
  always_comb begin
    busy       = (state_q != S_IDLE);
    sample_now = (cnt_q == '0);
    good_frame = (state_q == S_STOP) && sample_now && rx_s_q;
    bad_frame  = (state_q == S_STOP) && sample_now && !rx_s_q;
  end

  // Handoff register: load a good frame when the consumer has room, otherwise pulse overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= bad_frame;
      overrun_q     <= 1'b0;
      if (valid_q && ready) valid_q <= 1'b0;
      if (good_frame) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames bit-banged onto rx at 17 clk/bit, with a scoreboard checked by a negedge monitor.
module tb_uart_receiver;

  localparam int NB  = 8;
  localparam int OS  = 16;
  localparam int BIT = OS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ready;
  logic [NB-1:0] data;
  logic          valid;
  logic          frame_error;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .UART_BITS_TRANSFERED(NB),
    .OVERSAMPLE          (OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [NB-1:0] exp_q[$];
  int            exp_fe = 0;
  int            exp_ov = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_fe    = 1'b0;
  logic          prev_ov    = 1'b0;
  logic [NB-1:0] held_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented beat and each pulse against what the stimulus queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && (!prev_valid || prev_ready)) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(data), 32'hFFFF_FFFF);
        else                   check("valid_data", 32'(data), 32'(exp_q.pop_front()));
      end
      if (valid && prev_valid && !prev_ready) check("data_stable", 32'(data), 32'(held_data));
      if (frame_error) begin
        check("frame_error_width", 32'(prev_fe), 0);
        check("frame_error_expected", 32'(exp_fe > 0), 1);
        if (exp_fe > 0) exp_fe--;
      end
      if (overrun) begin
        check("overrun_width", 32'(prev_ov), 0);
        check("overrun_expected", 32'(exp_ov > 0), 1);
        if (exp_ov > 0) exp_ov--;
      end
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_fe    = frame_error;
    prev_ov    = overrun;
    held_data  = data;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [NB-1:0] b);
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      step(BIT);
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] b);
    send_data(b);
    rx = 1'b1;
    step(BIT);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || exp_fe != 0 || exp_ov != 0) && t < 400) begin
      step(1);
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + exp_fe + exp_ov), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    step(4);
    check("rst_data",  32'(data), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_fe",    32'(frame_error), 0);
    check("rst_ov",    32'(overrun), 0);
    check("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    step(10);

    // Single frame 0xA5, ready held high, with a latency measurement.
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5);
      begin
        step(30);
        check("busy_mid_frame", 32'(busy), 1);
        lat = 30;
        while (!valid && lat < 200) begin
          step(1);
          lat++;
        end
        check("latency_in_window", 32'(lat >= 163 && lat <= 165), 1);
      end
    join
    wait_drain("a5");
    step(2);
    check("valid_pulse_one_cycle", 32'(valid), 0);
    check("idle_after_a5", 32'(busy), 0);

    // Back-to-back frames, no idle gap beyond the stop bit.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'h3C);
    wait_drain("b2b");

    // A 5-cycle glitch is rejected at the mid-start sample.
    step(20);
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    step(3);
    check("glitch_busy_in_start", 32'(busy), 1);
    step(20);
    check("glitch_back_idle", 32'(busy), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A);
    wait_drain("5a");

    // Framing error: the stop bit is low and the line stays low for 40 cycles.
    exp_fe = 1;
    send_data(8'h81);
    rx = 1'b0;
    step(40);
    check("break_busy", 32'(busy), 1);
    check("break_no_valid", 32'(valid), 0);
    check("break_fe_seen", 32'(exp_fe), 0);
    rx = 1'b1;
    step(6);
    check("break_exit_idle", 32'(busy), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42);
    wait_drain("42");

    // Overrun: the consumer stalls, so the second frame is dropped.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11);
    wait_drain("11");
    exp_ov = 1;
    send_frame(8'h22);
    wait_drain("22_overrun");
    check("overrun_valid_held", 32'(valid), 1);
    check("overrun_data_held", 32'(data), 32'h11);
    ready = 1'b1;
    step(1);
    check("valid_clears_after_ready", 32'(valid), 0);
    step(10);

    // Reset in mid-frame: it is held past the last data bit, so no tail of the frame is decoded.
    fork
      send_frame(8'h77);
      begin
        step(60);
        rst = 1'b1;
        step(2);
        check("midrst_data",  32'(data), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_busy",  32'(busy), 0);
        check("midrst_fe",    32'(frame_error), 0);
        check("midrst_ov",    32'(overrun), 0);
        step(98);
        rst = 1'b0;
      end
    join
    step(5);
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_no_valid", 32'(valid), 0);
    exp_q.push_back(8'h99);
    send_frame(8'h99);
    wait_drain("99");
    check("final_data", 32'(data), 32'h99);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001: Parameter UART_BITS_TRANSFERED, default 8, data bits per frame (>=1).
REQ-002: Parameter OVERSAMPLE, default 16; bit period BIT_CYCLES = OVERSAMPLE+1 clk cycles, matching the team transmitter.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006: data  output  UART_BITS_TRANSFERED  last accepted frame payload, LSB received first.
REQ-007: valid  output  1  data holds an unconsumed frame.
REQ-008: ready  input  1  consumer accepts data when valid && ready.
REQ-009: frame_error  output  1  one-cycle pulse when the sampled stop bit is 0.
REQ-010: overrun  output  1  one-cycle pulse when a good frame is dropped because valid && !ready.
REQ-011: busy  output  1  high in every state except IDLE.

Function
REQ-012: rx shall pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-013: States shall be IDLE, START, DATA, STOP, BREAK, held in one state register plus a tick counter and a bit index.
REQ-014: IDLE -> START on a falling edge of rx_s (previous rx_s 1, current 0); tick counter loaded with OVERSAMPLE/2 (integer division).
REQ-015: START: counter decrements each cycle; at 0, rx_s sampled; if 0 -> DATA with counter = OVERSAMPLE, bit index 0; if 1 -> IDLE (glitch rejected, no outputs asserted).
REQ-016: DATA: counter decrements each cycle; at 0, rx_s stored into shift register bit [bit index], counter reloaded to OVERSAMPLE; after bit index UART_BITS_TRANSFERED-1 -> STOP, else index+1.
REQ-017: Consecutive samples shall be exactly BIT_CYCLES clk cycles apart, starting from the mid-start sample.
REQ-018: STOP: counter decrements; at 0, rx_s sampled; if 1 -> frame good, -> IDLE; if 0 -> frame_error pulse next cycle, -> BREAK.
REQ-019: BREAK: remain until rx_s == 1, then -> IDLE; no start detection while in BREAK.
REQ-020: Good frame completion: on the cycle after the stop sample, if valid == 0 or ready == 1 then data <= shift register and valid <= 1; else overrun pulses for one cycle, data and valid unchanged.
REQ-021: valid shall clear on the cycle after valid && ready, unless a good frame completes that same cycle (then valid stays 1 with new data).
REQ-022: data shall not change while valid == 1 except per REQ-021.
REQ-023: A framing-error frame shall never update data or valid.
REQ-024: Latency: valid rises 2 (sync) + OVERSAMPLE/2 + (UART_BITS_TRANSFERED+1)*BIT_CYCLES + 1 cycles after the rx falling edge at the pin, +-1 cycle for sync alignment.
REQ-025: A falling edge arriving in IDLE on the cycle a frame is reported shall be detected (back-to-back frames, no dead cycle).

Reset
REQ-026: While rst is high at a clk edge: state IDLE, counter 0, bit index 0, shift register 0, data 0, valid 0, frame_error 0, overrun 0, busy 0, synchronizer flops 1.
REQ-027: rst asserted mid-frame shall abandon the frame with no valid, frame_error or overrun pulse; after release, reception resumes only on a new falling edge.

Verification (OVERSAMPLE=16, BIT_CYCLES=17, UART_BITS_TRANSFERED=8)
REQ-028: Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 17 cycles/bit, ready=1 -> valid one cycle, data=0xA5, frame_error=0, overrun=0.
REQ-029: team uart_transmitter (same parameters) looped to rx, send 0x00, 0xFF, 0x3C back-to-back -> three valid beats in order with matching data.
REQ-030: 5-cycle low glitch on idle rx -> returns to IDLE, no valid/frame_error; following 0x5A frame received correctly.
REQ-031: Frame 0x81 with stop bit 0, rx held low 40 cycles then high -> frame_error one pulse, valid stays 0, busy high until rx high, next frame 0x42 received.
REQ-032: ready=0, send 0x11 then 0x22 -> valid=1 data=0x11, overrun one pulse at 0x22 completion, data stays 0x11; raise ready -> valid clears next cycle.
REQ-033: rst pulsed mid-DATA of frame 0x77 -> all outputs at reset values, no pulses; next 0x99 frame -> data=0x99.
